// File: rtl/fluxo_dados_n_if.sv
// Command/status bundle between the game control unit (master) and the
// fluxo_dados_n datapath (slave).
interface fluxo_dados_n_if #(
    parameter int W  = 4,
    parameter int AW = 4
);
    logic          zeraE;
    logic          contaE;
    logic          zeraL;
    logic          contaL;
    logic          zeraR;
    logic          registraR;
    logic          contaT;
    logic          escreveM;
    logic [W-1:0]  botoes;

    logic          botoesIgualMemoria;
    logic          enderecoIgualLimite;
    logic          enderecoMenorLimite;
    logic          fimE;
    logic          fimL;
    logic          jogada_feita;
    logic          jogada_valida;
    logic          timeout;
    logic          db_tem_jogada;
    logic [AW-1:0] db_contagem;
    logic [AW-1:0] db_limite;
    logic [W-1:0]  db_memoria;
    logic [W-1:0]  db_jogada;

    modport master (
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT, escreveM, botoes,
        input  botoesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL,
               jogada_feita, jogada_valida, timeout, db_tem_jogada,
               db_contagem, db_limite, db_memoria, db_jogada
    );

    modport slave (
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT, escreveM, botoes,
        output botoesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL,
               jogada_feita, jogada_valida, timeout, db_tem_jogada,
               db_contagem, db_limite, db_memoria, db_jogada
    );
endinterface

// File: rtl/fluxo_dados_n.sv
// Button-memory game datapath: address/limit counters, sequence memory, play register,
// press edge detector, one-hot validator and timeout. Define MEM_WRITE_EN for a writable memory.
module fluxo_dados_n #(
    parameter int W       = 4,
    parameter int AW      = 4,
    parameter int TIMEOUT = 4000,
    parameter int TW      = 16
) (
    input logic           clock,
    input logic           reset,
    fluxo_dados_n_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] endereco;
    logic [AW-1:0] limite;
    logic [W-1:0]  jogada;
    logic [W-1:0]  memoria;
    logic [W-1:0]  mem_rd;
    logic          prev;
    logic [TW-1:0] conta_t;
    logic          tem_jogada;
    logic          fim_timeout;

    // Power-on sequence pattern: a single lit button that walks across the W buttons.
    function automatic logic [W-1:0] rom_word(input int i);
        return W'(1) << (i % W);
    endfunction

    assign tem_jogada  = |bus.botoes;
    assign fim_timeout = (conta_t == TW'(TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset || bus.zeraE)   endereco <= '0;
        else if (bus.contaE)      endereco <= endereco + 1'b1;

        if (reset || bus.zeraL)   limite <= '0;
        else if (bus.contaL)      limite <= limite + 1'b1;

        if (reset || bus.zeraR)   jogada <= '0;
        else if (bus.registraR)   jogada <= bus.botoes;

        if (reset || bus.zeraL)   prev <= 1'b0;
        else                      prev <= tem_jogada;

        if (reset || !bus.contaT) conta_t <= '0;
        else if (fim_timeout)     conta_t <= '0;
        else                      conta_t <= conta_t + 1'b1;

        if (reset)                memoria <= '0;
        else                      memoria <= mem_rd;
    end

`ifdef MEM_WRITE_EN
    logic [W-1:0] mem [DEPTH];

    // NOTE: this array is reset on purpose, since reset must restore the
    // power-on sequence; memories without that need should not be reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= rom_word(i);
        end else if (bus.escreveM) begin
            mem[endereco] <= jogada;
        end
    end

    assign mem_rd = mem[endereco];
`else
    logic unused_escreve_m;

    assign unused_escreve_m = bus.escreveM;
    assign mem_rd           = rom_word(int'(endereco));
`endif

    assign bus.botoesIgualMemoria  = (memoria == jogada);
    assign bus.enderecoIgualLimite = (endereco == limite);
    assign bus.enderecoMenorLimite = (endereco < limite);
    assign bus.fimE                = &endereco;
    assign bus.fimL                = &limite;
    assign bus.jogada_feita        = !reset && tem_jogada && !prev;
    assign bus.jogada_valida       = (jogada != '0) && ((jogada & (jogada - 1'b1)) == '0);
    assign bus.timeout             = bus.contaT && fim_timeout;
    assign bus.db_tem_jogada       = tem_jogada;
    assign bus.db_contagem         = endereco;
    assign bus.db_limite           = limite;
    assign bus.db_memoria          = memoria;
    assign bus.db_jogada           = jogada;
endmodule

// File: tb/tb_fluxo_dados_n.sv
// Self-checking bench for fluxo_dados_n; db_memoria is checked every cycle through a
// read scoreboard, the other features by per-scenario tasks. Honours MEM_WRITE_EN.
module tb_fluxo_dados_n;
    localparam int W       = 4;
    localparam int AW      = 4;
    localparam int TIMEOUT = 4000;
    localparam int TW      = 16;
    localparam int DEPTH   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fluxo_dados_n_if #(.W(W), .AW(AW)) bus ();

    fluxo_dados_n #(.W(W), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  mem_q [$];
    logic [W-1:0]  model_mem [DEPTH];
    logic [AW-1:0] m_end = '0;
    logic [W-1:0]  m_jog = '0;

    task automatic idle_inputs();
        bus.zeraE = 0; bus.contaE = 0; bus.zeraL = 0; bus.contaL = 0;
        bus.zeraR = 0; bus.registraR = 0; bus.contaT = 0; bus.escreveM = 0;
        bus.botoes = '0;
    endtask

    // One clock: push the expected read data, clock, update the model, pop and compare.
    task automatic tick();
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        exp_v = reset ? '0 : model_mem[m_end];
        mem_q.push_back(exp_v);
        @(posedge clock);
`ifdef MEM_WRITE_EN
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 4'b0001 << (i % 4);
        end else if (bus.escreveM) begin
            model_mem[m_end] = m_jog;
        end
`endif
        if (reset || bus.zeraE)      m_end = '0;
        else if (bus.contaE)         m_end = m_end + 1'b1;
        if (reset || bus.zeraR)      m_jog = '0;
        else if (bus.registraR)      m_jog = bus.botoes;
        #1;
        got   = bus.db_memoria;
        exp_v = mem_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL mem_scoreboard addr=%0d got=%b exp=%b", m_end, got, exp_v);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        idle_inputs();
        reset = 1'b1;
        bus.botoes = 4'b0100;
        #1;
        checks++;
        if (bus.jogada_feita !== 1'b0) begin
            failures++; $display("FAIL feita_in_reset got=%b exp=0", bus.jogada_feita);
        end
        tick();
        reset = 1'b0;
        bus.botoes = '0;
        #1;
        flags = {bus.enderecoIgualLimite, bus.enderecoMenorLimite, bus.fimE, bus.fimL,
                 bus.botoesIgualMemoria, bus.jogada_valida, bus.timeout};
        checks++;
        if (flags !== 7'b1000100) begin
            failures++; $display("FAIL reset_flags got=%b exp=1000100", flags);
        end
        checks++;
        if ({bus.db_contagem, bus.db_limite, bus.db_jogada} !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs got=%h exp=000", {bus.db_contagem, bus.db_limite, bus.db_jogada});
        end
        tick();
        checks++;
        if (bus.db_memoria !== 4'b0001 || bus.botoesIgualMemoria !== 1'b0) begin
            failures++;
            $display("FAIL reset_read got=%b/%b exp=0001/0", bus.db_memoria, bus.botoesIgualMemoria);
        end
    endtask

    task automatic test_counters();
        int bad = 0;
        idle_inputs();
        bus.contaE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.db_contagem !== AW'(i) || bus.fimE !== (i == 15)) bad++;
            tick();
        end
        bus.contaE = 1'b0;
        #1;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL address_sweep bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (bus.db_contagem !== 4'd0 || bus.fimE !== 1'b0) begin
            failures++; $display("FAIL address_wrap got=%0d fimE=%b exp=0/0", bus.db_contagem, bus.fimE);
        end
        bus.contaE = 1'b1;
        ticks(3);
        bus.zeraE = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.db_contagem !== 4'd0) begin
            failures++; $display("FAIL zeraE_priority got=%0d exp=0", bus.db_contagem);
        end
        bus.contaL = 1'b1;
        ticks(15);
        bus.contaL = 1'b0;
        #1;
        checks++;
        if (bus.db_limite !== 4'd15 || bus.fimL !== 1'b1) begin
            failures++; $display("FAIL limit_end got=%0d fimL=%b exp=15/1", bus.db_limite, bus.fimL);
        end
        bus.contaL = 1'b1;
        bus.zeraL  = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.db_limite !== 4'd0 || bus.fimL !== 1'b0) begin
            failures++; $display("FAIL zeraL_priority got=%0d fimL=%b exp=0/0", bus.db_limite, bus.fimL);
        end
    endtask

    task automatic test_compare();
        idle_inputs();
        bus.zeraE = 1'b1; bus.zeraL = 1'b1;
        tick();
        idle_inputs();
        bus.contaL = 1'b1;
        ticks(3);
        bus.contaL = 1'b0;
        bus.contaE = 1'b1;
        tick();
        bus.contaE = 1'b0;
        #1;
        checks++;
        if ({bus.enderecoMenorLimite, bus.enderecoIgualLimite} !== 2'b10) begin
            failures++;
            $display("FAIL less_than got=%b%b exp=10", bus.enderecoMenorLimite, bus.enderecoIgualLimite);
        end
        bus.contaE = 1'b1;
        ticks(2);
        bus.contaE = 1'b0;
        #1;
        checks++;
        if ({bus.enderecoMenorLimite, bus.enderecoIgualLimite} !== 2'b01) begin
            failures++;
            $display("FAIL equal got=%b%b exp=01", bus.enderecoMenorLimite, bus.enderecoIgualLimite);
        end
        bus.contaE = 1'b1;
        tick();
        bus.contaE = 1'b0;
        #1;
        checks++;
        if ({bus.enderecoMenorLimite, bus.enderecoIgualLimite} !== 2'b00) begin
            failures++;
            $display("FAIL greater got=%b%b exp=00", bus.enderecoMenorLimite, bus.enderecoIgualLimite);
        end
    endtask

    task automatic test_press();
        int pulses = 0;
        idle_inputs();
        bus.zeraE = 1'b1;
        tick();
        idle_inputs();
        bus.contaE = 1'b1;
        ticks(2);
        bus.contaE = 1'b0;
        bus.botoes = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.jogada_feita === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL held_press pulses=%0d exp=1", pulses);
        end
        bus.registraR = 1'b1;
        tick();
        bus.registraR = 1'b0;
        #1;
        checks++;
        if (bus.db_jogada !== 4'b0100 || bus.jogada_valida !== 1'b1 || bus.botoesIgualMemoria !== 1'b1) begin
            failures++;
            $display("FAIL register_play got=%b valida=%b igual=%b exp=0100/1/1",
                     bus.db_jogada, bus.jogada_valida, bus.botoesIgualMemoria);
        end
        bus.botoes = '0;
        tick();
        bus.botoes = 4'b0110;
        #1;
        checks++;
        if (bus.jogada_feita !== 1'b1) begin
            failures++; $display("FAIL repress got=%b exp=1", bus.jogada_feita);
        end
        bus.registraR = 1'b1;
        tick();
        bus.registraR = 1'b0;
        #1;
        checks++;
        if (bus.jogada_valida !== 1'b0 || bus.jogada_feita !== 1'b0) begin
            failures++;
            $display("FAIL two_hot got valida=%b feita=%b exp=0/0", bus.jogada_valida, bus.jogada_feita);
        end
        bus.zeraL = 1'b1;
        tick();
        bus.zeraL = 1'b0;
        #1;
        checks++;
        if (bus.jogada_feita !== 1'b1) begin
            failures++; $display("FAIL zeraL_clears_prev got=%b exp=1", bus.jogada_feita);
        end
        bus.zeraR = 1'b1;
        bus.registraR = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.db_jogada !== 4'b0000) begin
            failures++; $display("FAIL zeraR_priority got=%b exp=0000", bus.db_jogada);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int early  = 0;
        idle_inputs();
        tick();
        bus.contaT = 1'b1;
        for (int c = 1; c <= 8001; c++) begin
            #1;
            if (bus.timeout === 1'b1) pulses++;
            if ((c == 4000 || c == 8000) && bus.timeout !== 1'b1) early++;
            tick();
        end
        checks++;
        if (pulses != 2 || early != 0) begin
            failures++; $display("FAIL timeout_periodic pulses=%0d missed=%0d exp=2/0", pulses, early);
        end
        bus.contaT = 1'b0;
        tick();
        bus.contaT = 1'b1;
        ticks(3998);
        bus.contaT = 1'b0;
        #1;
        checks++;
        if (bus.timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_when_low got=%b exp=0", bus.timeout);
        end
        tick();
        bus.contaT = 1'b1;
        pulses = 0;
        for (int c = 1; c < 4000; c++) begin
            #1;
            if (bus.timeout === 1'b1) pulses++;
            tick();
        end
        #1;
        checks++;
        if (pulses != 0 || bus.timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_restart early=%0d at4000=%b exp=0/1", pulses, bus.timeout);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_game();
        idle_inputs();
        bus.contaE = 1'b1; bus.contaL = 1'b1; bus.contaT = 1'b1;
        bus.botoes = 4'b1000; bus.registraR = 1'b1;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({bus.db_contagem, bus.db_limite, bus.db_jogada, bus.db_memoria} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_game got=%h exp=0000",
                     {bus.db_contagem, bus.db_limite, bus.db_jogada, bus.db_memoria});
        end
        tick();
    endtask

`ifdef MEM_WRITE_EN
    task automatic test_mem_write();
        idle_inputs();
        bus.zeraE = 1'b1; bus.botoes = 4'b1000; bus.registraR = 1'b1;
        tick();
        idle_inputs();
        bus.escreveM = 1'b1;
        tick();
        bus.escreveM = 1'b0;
        checks++;
        if (bus.db_memoria !== 4'b0001) begin
            failures++; $display("FAIL write_cycle_read got=%b exp=0001", bus.db_memoria);
        end
        tick();
        checks++;
        if (bus.db_memoria !== 4'b1000) begin
            failures++; $display("FAIL write_after got=%b exp=1000", bus.db_memoria);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.db_memoria !== 4'b0001) begin
            failures++; $display("FAIL reset_restores_rom got=%b exp=0001", bus.db_memoria);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 4'b0001 << (i % 4);
        idle_inputs();
        test_reset();
        test_counters();
        test_compare();
        test_press();
        test_timeout();
        test_reset_mid_game();
`ifdef MEM_WRITE_EN
        test_mem_write();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fluxo_dados_n.md
# fluxo_dados_n

Parametrised datapath for the button-memory game: sequence address and limit counters, a sequence memory, a play register, a press edge detector, a one-hot play validator and a programmable timeout. It generalises button width, sequence depth and timeout length, and adds an optional in-game writable sequence memory. The block sits under the game's control unit. It receives only counter and register commands and returns status flags plus debug buses.

## Interface
- `W`, 4: button/data width (≥2)
- `AW`, 4: address width; sequence depth `DEPTH = 2**AW`
- `TIMEOUT`, 4000: cycles of `contaT` before `timeout` fires (≥2)
- `TW`, 16: timeout counter width; `2**TW ≥ TIMEOUT`

Ports:
- `clock` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `zeraE`, `contaE` in 1: address counter clear / increment
- `zeraL`, `contaL` in 1: limit counter clear / increment
- `zeraR`, `registraR` in 1: play register clear / load
- `contaT` in 1: timeout enable; low clears the timeout counter
- `escreveM` in 1: write the play register into memory at the current address (only with the macro)
- `botoes` in W: raw button levels
- `botoesIgualMemoria` out 1: memory data == play register
- `enderecoIgualLimite`, `enderecoMenorLimite` out 1: address ==/< limit
- `fimE`, `fimL` out 1: address / limit == DEPTH-1
- `jogada_feita` out 1: one-cycle pulse on a press
- `jogada_valida` out 1: play register is one-hot
- `timeout` out 1: one-cycle timeout pulse
- `db_tem_jogada` out 1: OR of `botoes`
- `db_contagem`, `db_limite` out AW; `db_memoria`, `db_jogada` out W

## Operation
- **Address counter**
  - Priority: `reset` > `zeraE` > `contaE`.
  - Wraps DEPTH-1 → 0.
  - `fimE` is combinational on the count.
- **Limit counter**: identical behaviour on `zeraL`/`contaL`, driving `fimL`.
- **Play register**
  - Priority: `reset` > `zeraR` > `registraR` (loads `botoes`).
- **Edge detector**
  - `prev` is a registered copy of OR(`botoes`).
  - `jogada_feita = OR(botoes) & ~prev`, combinational.
  - Forced 0 while `reset` is high; `prev` is cleared by `reset` and by `zeraL`.
- **Memory read**
  - Synchronous: `db_memoria` register ← mem[address] every cycle.
  - Read-before-write on a same-cycle write.
- **Comparators**
  - `botoesIgualMemoria = (db_memoria == db_jogada)`.
  - `enderecoMenorLimite` is an unsigned compare over AW bits.
  - `jogada_valida` = exactly one bit of the play register set.
- **Timeout counter**
  - Counts while `contaT`; synchronously cleared when `contaT` is 0.
  - `timeout` = `contaT` & (count == TIMEOUT-1).
  - The counter then wraps to 0, so `timeout` pulses once every TIMEOUT cycles of continuous `contaT`.

## Timing
- **Reset values (cycle after `reset`)**
  - Address, limit, play register, `prev`, timeout count and `db_memoria` register are all 0.
  - Resulting outputs: `enderecoIgualLimite`=1, `enderecoMenorLimite`=0, `fimE`=`fimL`=0, `botoesIgualMemoria`=1, `jogada_valida`=0, `timeout`=0.
- **Memory read latency**: 1 cycle. After an address change, `db_memoria`/`botoesIgualMemoria` are valid one cycle later.
- **Play register latency**: `registraR` in cycle n → `db_jogada` updated in cycle n+1, and the compare is valid in n+1.
- **Simultaneous commands**: clear wins over increment on every counter; `reset` mid-game aborts everything in one cycle.
- **Held button**: produces exactly one `jogada_feita` pulse; release and re-press produces another.

## Configuration
- **`MEM_WRITE_EN` undefined**
  - Memory is a fixed ROM: mem[i] = 1 << (i mod W).
  - `escreveM` is ignored.
- **`MEM_WRITE_EN` defined**
  - Memory is a DEPTH×W register array.
  - `reset` reloads the ROM pattern above.
  - `escreveM` writes `db_jogada` to mem[address] at the clock edge, with read-before-write.

## Test plan
- Reset, then idle 1 cycle → all counters 0, `db_memoria`=4'b0001, `enderecoIgualLimite`=1, `botoesIgualMemoria`=0 (register 0 vs 1).
- 16× `contaE` with W=4, AW=4 → `fimE`=1 at count 15, count 0 after the 16th; `contaE`+`zeraE` together → 0.
- `contaL` ×3, `contaE` ×1 → `enderecoMenorLimite`=1; two more `contaE` → `enderecoIgualLimite`=1.
- `botoes`=4'b0100 held 5 cycles → one `jogada_feita` pulse; `registraR` → `db_jogada`=4'b0100, `jogada_valida`=1; at address 2 → `botoesIgualMemoria`=1.
- `contaT` held 8001 cycles, TIMEOUT=4000 → `timeout` pulses at cycles 4000 and 8000 only; drop `contaT` at cycle 3999 and re-raise → no pulse until 4000 cycles later.
- `MEM_WRITE_EN`: register 4'b1000, `escreveM` at address 0 → `db_memoria` is 0001 in the write cycle and 1000 thereafter; `reset` restores 0001.
